// File: rtl/pp_pipeline_accel_fifo_rr_arb.sv
// Round-robin burst arbiter merging N_REQ fall-through FIFOs into one downstream FIFO.
// Define PP_ARB_SRC_TAG_EN to add the out_src beat source tag port.
module pp_pipeline_accel_fifo_rr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4,
  localparam int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arb_en,
  input  logic [N_REQ-1:0]            req_empty_n,
  output logic [N_REQ-1:0]            req_read,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_dout,
  input  logic                        out_full_n,
  output logic                        out_write,
  output logic [DATA_WIDTH-1:0]       out_din,
`ifdef PP_ARB_SRC_TAG_EN
  output logic [SRC_W-1:0]            out_src,
`endif
  output logic                        grant_valid,
  output logic [SRC_W-1:0]            grant_idx
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [SRC_W-1:0] rr_ptr;
  logic [7:0]      beat_cnt;

  logic            any_req;
  logic            hi_hit;
  logic [SRC_W-1:0] hi_idx;
  logic [SRC_W-1:0] lo_idx;
  logic [SRC_W-1:0] scan_idx;

  logic                  g_empty_n;
  logic [DATA_WIDTH-1:0] g_dout;
  logic                  xfer;
  logic                  burst_done;
  logic [SRC_W-1:0]      next_ptr;

  // Lowest set index at or above rr_ptr wins; otherwise wrap to the lowest set index overall.
  always_comb begin
    any_req = 1'b0;
    hi_hit  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_empty_n[i]) begin
        any_req = 1'b1;
        lo_idx  = SRC_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_hit = 1'b1;
          hi_idx = SRC_W'(i);
        end
      end
    end
  end

  assign scan_idx = hi_hit ? hi_idx : lo_idx;

  always_comb begin
    g_empty_n = 1'b0;
    g_dout    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        g_empty_n = req_empty_n[i];
        g_dout    = req_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer       = (state == XFER) && g_empty_n && out_full_n;
  assign burst_done = (beat_cnt == 8'(BURST - 1));
  assign next_ptr   = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_read = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        req_read[i] = xfer;
      end
    end
  end

  assign out_write   = xfer;
  assign out_din     = xfer ? g_dout : '0;
  assign grant_valid = (state == XFER);

`ifdef PP_ARB_SRC_TAG_EN
  assign out_src = xfer ? grant_idx : '0;
`endif

  // A stall (source non-empty, downstream full) neither counts a beat nor releases the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en && any_req) begin
            grant_idx <= scan_idx;
            beat_cnt  <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (!g_empty_n || (xfer && burst_done)) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
            if (xfer) begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_rr_arb.sv
// Directed bench for pp_pipeline_accel_fifo_rr_arb with a small per-requester FIFO model.
module tb_pp_pipeline_accel_fifo_rr_arb;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          arb_en;
  logic [N-1:0]  req_empty_n;
  logic [N-1:0]  req_read;
  logic [N*DW-1:0] req_dout;
  logic          out_full_n;
  logic          out_write;
  logic [DW-1:0] out_din;
`ifdef PP_ARB_SRC_TAG_EN
  logic [1:0]    out_src;
`endif
  logic          grant_valid;
  logic [1:0]    grant_idx;

  int checks;
  int errors;

  int        avail [N];
  int        head  [N];
  logic [7:0] base [N];

  pp_pipeline_accel_fifo_rr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .arb_en     (arb_en),
    .req_empty_n(req_empty_n),
    .req_read   (req_read),
    .req_dout   (req_dout),
    .out_full_n (out_full_n),
    .out_write  (out_write),
    .out_din    (out_din),
`ifdef PP_ARB_SRC_TAG_EN
    .out_src    (out_src),
`endif
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic arb, input logic full);
    arb_en     = arb;
    out_full_n = full;
  endtask

  task automatic refreshInputs();
    for (int i = 0; i < N; i++) begin
      req_empty_n[i]          = (avail[i] > 0);
      req_dout[i*DW +: DW]    = base[i] + 8'(head[i]);
    end
  endtask

  // Checks one cycle's combinational outputs, then clocks and pops the model FIFOs that were read.
  task automatic expectCycle(input string tag, input bit exp_write, input bit exp_valid,
                             input int exp_gidx, input logic [7:0] exp_din);
    logic [N-1:0] rd;
    logic [N-1:0] exp_rd;
    logic [N-1:0] one;
    one = 4'b0001;
    exp_rd = exp_write ? (one << exp_gidx) : '0;
    refreshInputs();
    #1;
    checkOutput({tag, "_wr"},   32'(out_write),   32'(exp_write));
    checkOutput({tag, "_gv"},   32'(grant_valid), 32'(exp_valid));
    checkOutput({tag, "_gi"},   32'(grant_idx),   32'(exp_gidx));
    checkOutput({tag, "_din"},  32'(out_din),     32'(exp_din));
    checkOutput({tag, "_rd"},   32'(req_read),    32'(exp_rd));
`ifdef PP_ARB_SRC_TAG_EN
    checkOutput({tag, "_src"},  32'(out_src),     exp_write ? 32'(exp_gidx) : 32'd0);
`endif
    rd = req_read;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i]) begin
        head[i]++;
        if (avail[i] > 0) avail[i]--;
      end
    end
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    refreshInputs();
    #1;
    checkOutput({tag, "_wr"}, 32'(out_write),   32'd0);
    checkOutput({tag, "_rd"}, 32'(req_read),    32'd0);
    checkOutput({tag, "_din"},32'(out_din),     32'd0);
    checkOutput({tag, "_gv"}, 32'(grant_valid), 32'd0);
    checkOutput({tag, "_gi"}, 32'(grant_idx),   32'd0);
`ifdef PP_ARB_SRC_TAG_EN
    checkOutput({tag, "_src"},32'(out_src),     32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) head[i] = 0;
  endtask

  initial begin
    int g;
    int k;
    int ph;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req_empty_n = '0;
    req_dout    = '0;
    applyStimulus(1'b1, 1'b1);

    // Single source: all requesters streaming, grants 0,1,2,3,0 with 4 beats + 1 idle each.
    for (int i = 0; i < N; i++) begin
      avail[i] = 1000;
      head[i]  = 0;
      base[i]  = 8'(i * 64);
    end
    doReset("rst0");
    for (int c = 0; c < 25; c++) begin
      k  = c / 5;
      ph = c % 5;
      if (ph == 0) begin
        expectCycle($sformatf("t1c%0d", c), 1'b0, 1'b0, (c == 0) ? 0 : ((k - 1) % 4), 8'h00);
      end else begin
        g = k % 4;
        expectCycle($sformatf("t1c%0d", c), 1'b1, 1'b1, g, 8'(g * 64 + 4 * (k / 4) + ph - 1));
      end
    end

    // Early release: req1 has two beats, then the pointer moves to 2.
    for (int i = 0; i < N; i++) avail[i] = 0;
    avail[1] = 2;
    base[1]  = 8'hA1;
    doReset("rst1");
    expectCycle("t2c0", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t2c1", 1'b1, 1'b1, 1, 8'hA1);
    expectCycle("t2c2", 1'b1, 1'b1, 1, 8'hA2);
    expectCycle("t2c3", 1'b0, 1'b1, 1, 8'h00);
    avail[0] = 1; base[0] = 8'h10;
    avail[1] = 1;
    avail[2] = 1; base[2] = 8'h20;
    expectCycle("t2c4", 1'b0, 1'b0, 1, 8'h00);
    expectCycle("t2c5", 1'b1, 1'b1, 2, 8'h20);
    expectCycle("t2c6", 1'b0, 1'b1, 2, 8'h00);
    expectCycle("t2c7", 1'b0, 1'b0, 2, 8'h00);
    expectCycle("t2c8", 1'b1, 1'b1, 0, 8'h10);
    expectCycle("t2c9", 1'b0, 1'b1, 0, 8'h00);
    expectCycle("t2c10", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t2c11", 1'b1, 1'b1, 1, 8'hA3);
    expectCycle("t2c12", 1'b0, 1'b1, 1, 8'h00);
    expectCycle("t2c13", 1'b0, 1'b0, 1, 8'h00);

    // Backpressure: three stalled cycles after beat 2 of a req0 burst.
    for (int i = 0; i < N; i++) avail[i] = 0;
    avail[0] = 1000;
    base[0]  = 8'h50;
    doReset("rst2");
    expectCycle("t3c0", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t3c1", 1'b1, 1'b1, 0, 8'h50);
    expectCycle("t3c2", 1'b1, 1'b1, 0, 8'h51);
    applyStimulus(1'b1, 1'b0);
    expectCycle("t3c3", 1'b0, 1'b1, 0, 8'h00);
    expectCycle("t3c4", 1'b0, 1'b1, 0, 8'h00);
    expectCycle("t3c5", 1'b0, 1'b1, 0, 8'h00);
    applyStimulus(1'b1, 1'b1);
    expectCycle("t3c6", 1'b1, 1'b1, 0, 8'h52);
    expectCycle("t3c7", 1'b1, 1'b1, 0, 8'h53);
    expectCycle("t3c8", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t3c9", 1'b1, 1'b1, 0, 8'h54);
    expectCycle("t3c10", 1'b1, 1'b1, 0, 8'h55);

    // Reset in the middle of a req2 burst, then the first grant restarts at req0.
    for (int i = 0; i < N; i++) avail[i] = 0;
    avail[2] = 1000;
    base[2]  = 8'h80;
    doReset("rst3");
    expectCycle("t4c0", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t4c1", 1'b1, 1'b1, 2, 8'h80);
    expectCycle("t4c2", 1'b1, 1'b1, 2, 8'h81);
    doReset("rstmid");
    for (int i = 0; i < N; i++) avail[i] = 1000;
    base[0] = 8'h30;
    expectCycle("t4c3", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t4c4", 1'b1, 1'b1, 0, 8'h30);
    expectCycle("t4c5", 1'b1, 1'b1, 0, 8'h31);

    // Enable gating: arb_en drops during beat 1; the burst completes, then no new grants.
    for (int i = 0; i < N; i++) avail[i] = 1000;
    base[0] = 8'h60;
    base[1] = 8'h70;
    doReset("rst4");
    expectCycle("t5c0", 1'b0, 1'b0, 0, 8'h00);
    applyStimulus(1'b0, 1'b1);
    expectCycle("t5c1", 1'b1, 1'b1, 0, 8'h60);
    expectCycle("t5c2", 1'b1, 1'b1, 0, 8'h61);
    expectCycle("t5c3", 1'b1, 1'b1, 0, 8'h62);
    expectCycle("t5c4", 1'b1, 1'b1, 0, 8'h63);
    for (int c = 5; c < 9; c++) begin
      expectCycle($sformatf("t5c%0d", c), 1'b0, 1'b0, 0, 8'h00);
    end
    applyStimulus(1'b1, 1'b1);
    expectCycle("t5c9", 1'b0, 1'b0, 0, 8'h00);
    expectCycle("t5c10", 1'b1, 1'b1, 1, 8'h70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_fifo_rr_arb.md
# pp_pipeline_accel_fifo_rr_arb

Round-robin arbiter that merges N_REQ upstream stream FIFOs (fall-through `empty_n`/`read`/`dout` read side) into one downstream stream FIFO (`full_n`/`write`/`din` write side) in the pp_pipeline_accel datapath. Each grant holds for a burst of up to BURST beats. A grant is released early when the granted FIFO runs empty. Data passes combinationally from the granted FIFO to the downstream FIFO, with zero added latency.

## Interface
Parameters:
- `N_REQ`, 4: number of upstream FIFOs, range 2..16.
- `DATA_WIDTH`, 8: beat width.
- `BURST`, 4: maximum beats per grant, range 1..255.
- `SRC_W`, derived: `max(1, clog2(N_REQ))`.

Ports:
- `clk`: input, 1 bit. Single clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `arb_en`: input, 1 bit. Low blocks new grants; a burst already in progress completes.
- `req_empty_n`: input, N_REQ bits. Per-upstream not-empty.
- `req_read`: output, N_REQ bits. Per-upstream read strobe, one-hot or zero.
- `req_dout`: input, N_REQ*DATA_WIDTH bits. Upstream head data; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_full_n`: input, 1 bit. Downstream not-full.
- `out_write`: output, 1 bit. Downstream write strobe.
- `out_din`: output, DATA_WIDTH bits. Downstream write data.
- `out_src`: output, SRC_W bits. Source index of the current beat. Present only with `PP_ARB_SRC_TAG_EN`.
- `grant_valid`: output, 1 bit. High while in the XFER state.
- `grant_idx`: output, SRC_W bits. Current or last granted requester.

## Operation
State machine with two states, IDLE and XFER. Registers:
- `state`
- `grant_idx`
- `rr_ptr`, SRC_W bits
- `beat_cnt`, 8 bits

IDLE:
- If `arb_en=1` and any `req_empty_n` bit is set, select the first set index scanning `rr_ptr, rr_ptr+1, …` modulo N_REQ.
- Latch that index into `grant_idx`, clear `beat_cnt`, and enter XFER.
- No transfer happens in IDLE.

XFER, with g = `grant_idx`:
- The transfer condition is `xfer = req_empty_n[g] & out_full_n`.
- Combinational outputs: `req_read[g] = xfer` (all other bits 0), `out_write = xfer`, `out_din = xfer ? req_dout[g] : 0`.
- On `xfer`, `beat_cnt` increments by 1.
- Release when `xfer` and `beat_cnt == BURST-1` (burst done), or when `req_empty_n[g]==0` (source dry, no transfer that cycle).
- On release: `rr_ptr <= (g+1 == N_REQ) ? 0 : g+1`, then go to IDLE.
- `out_full_n=0` with `req_empty_n[g]=1` stalls: hold XFER and hold `beat_cnt`. A stall never releases the grant.

Other rules:
- `arb_en` is sampled only in IDLE.
- `req_read` and `out_write` never assert in IDLE.
- `req_read` never targets a FIFO whose `empty_n` is 0.
- `req_read` never asserts while `out_full_n` is 0.
- Beats from a single grant stay contiguous and in order. No beat is duplicated or lost.

## Timing
- Data latency is 0 cycles: `out_din`/`out_write` follow `req_dout`/`req_empty_n`/`out_full_n` combinationally within XFER.
- Arbitration overhead is 1 IDLE cycle per grant. Maximum throughput is BURST beats per BURST+1 cycles.
- On reset assertion (asynchronous, effective immediately): `state=IDLE`, `grant_idx=0`, `rr_ptr=0`, `beat_cnt=0`.
- Outputs during and after reset: `req_read=0`, `out_write=0`, `out_din=0`, `grant_valid=0`, `grant_idx=0`, `out_src=0`.
- Reset in the middle of a burst aborts it. A partial burst already written stays downstream. The first grant after reset starts scanning at index 0.
- Reset deassertion must be synchronized externally to `clk`.
- Fairness: after releasing requester g, g has the lowest priority in the next scan. Any requester with a constant `empty_n` is granted within N_REQ-1 intervening grants.
- With `BURST=1`, every grant carries at most one beat.

## Configuration
- `PP_ARB_SRC_TAG_EN` defined:
  - The `out_src` port exists.
  - `out_src = xfer ? grant_idx : 0`, valid in the same cycle as `out_write`.
  - Its reset value is 0.
- `PP_ARB_SRC_TAG_EN` not defined:
  - The `out_src` port is absent.
  - No tag logic is present.
  - All other behaviour is identical.

## Test plan
- **Single source:** reset, then all requesters hold `empty_n=1`, `out_full_n=1`, `BURST=4`, `N_REQ=4`, `arb_en=1`. Required: grants in order 0,1,2,3,0. Each grant gives 4 consecutive `out_write` cycles, followed by 1 idle cycle.
- **Early release:** req1 holds 2 beats, 0xA1 and 0xA2, and is the only requester. Required: `out_din` is 0xA1 then 0xA2. The grant releases on the next cycle (`empty_n=0`). `rr_ptr` becomes 2.
- **Backpressure:** during a req0 burst, `out_full_n=0` for 3 cycles after beat 2. Required: `req_read=0` and `out_write=0` during the stall. `beat_cnt` holds at 2, and the burst resumes and completes 4 beats total with no duplicated data.
- **Reset mid-burst:** assert `reset` asynchronously after beat 2 of a req2 grant. Required: `out_write`/`req_read` drop immediately and `grant_valid=0`. The next grant after reset goes to req0 when all requesters are non-empty.
- **Enable gating:** drop `arb_en` during beat 1 of a grant. Required: the burst finishes all 4 beats, then the arbiter stays in IDLE with zero writes until `arb_en=1`.
- **Tag, with `PP_ARB_SRC_TAG_EN` defined:** `N_REQ=4`, all requesters streaming. Required: `out_src` equals `grant_idx` on every `out_write` cycle, and is 0 otherwise.
